// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin drain of four NoC FIFOs onto one valid/ready link.
// Define NOC_ARB_GRANT_CNT_EN to add saturating per-FIFO grant counters (grant_cnt).
`timescale 1ns/1ps
module noc_output_arbiter #(
    parameter int DATA_W = 32
`ifdef NOC_ARB_GRANT_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [3:0]          fifo_empty,
    output logic [3:0]          fifo_rd_en,
    input  logic [4*DATA_W-1:0] fifo_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_port,
`ifdef NOC_ARB_GRANT_CNT_EN
    output logic [4*CNT_W-1:0]  grant_cnt,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        SEND
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          sel_q;
    logic [1:0]          last_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          port_q;
    logic [1:0]          pick;
    logic [1:0]          cand;
    logic                pick_ok;
    logic                handshake;

    // Scan farthest-first so the nearest non-empty FIFO after last_q wins.
    always_comb begin
        pick    = last_q;
        pick_ok = 1'b0;
        cand    = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (!fifo_empty[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (pick_ok) state_d = READ;
            READ: state_d = fifo_empty[sel_q] ? IDLE : WAIT;
            WAIT: state_d = SEND;
            SEND: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign handshake = (state_q == SEND) && out_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            data_q  <= '0;
            port_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_ok)
                sel_q <= pick;
            if (state_q == WAIT) begin
                data_q <= fifo_rdata[sel_q*DATA_W +: DATA_W];
                port_q <= sel_q;
            end
            if (handshake)
                last_q <= sel_q;
        end
    end

    // Read strobe is gated by empty so a vanished word never gets popped.
    always_comb begin
        fifo_rd_en = 4'b0000;
        if (state_q == READ && !fifo_empty[sel_q])
            fifo_rd_en[sel_q] = 1'b1;
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = data_q;
    assign out_port  = port_q;
    assign busy      = (state_q != IDLE);

`ifdef NOC_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 4; i++)
                cnt_q[i] <= '0;
        end else if (handshake && cnt_q[port_q] != '1) begin
            cnt_q[port_q] <= cnt_q[port_q] + 1'b1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: directed scoreboard bench for noc_output_arbiter.
// Behavioural FIFOs with 1-cycle read latency feed the DUT.
`timescale 1ns/1ps
module tb_noc_output_arbiter;

    localparam int DW = 32;
`ifdef NOC_ARB_GRANT_CNT_EN
    localparam int CW = 2;
`endif

    logic          clk = 1'b0;
    logic          n_rst;
    logic [3:0]    fifo_empty;
    logic [3:0]    fifo_rd_en;
    logic [4*DW-1:0] fifo_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_port;
    logic          busy;
`ifdef NOC_ARB_GRANT_CNT_EN
    logic [4*CW-1:0] grant_cnt;
`endif

    int n_chk = 0;
    int n_pass = 0;
    logic [DW-1:0] fq [4][$];
    logic [DW+1:0] exp_q [$];

    always #5 clk = ~clk;

`ifdef NOC_ARB_GRANT_CNT_EN
    noc_output_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
`else
    noc_output_arbiter #(.DATA_W(DW)) dut (
`endif
        .clk(clk),
        .n_rst(n_rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(fifo_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_port(out_port),
`ifdef NOC_ARB_GRANT_CNT_EN
        .grant_cnt(grant_cnt),
`endif
        .busy(busy)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: FIFO model pops on the strobe seen before the edge.
    task automatic tick();
        logic [3:0] rd;
        #2;
        rd = fifo_rd_en;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rd[i] && fq[i].size() > 0) begin
                fifo_rdata[i*DW +: DW] <= fq[i][0];
                void'(fq[i].pop_front());
            end
            fifo_empty[i] <= (fq[i].size() == 0);
        end
        @(negedge clk);
    endtask

    task automatic push(int p, logic [DW-1:0] w);
        fq[p].push_back(w);
        fifo_empty[p] <= 1'b0;
    endtask

    task automatic expect_word(int p, logic [DW-1:0] w);
        exp_q.push_back({2'(p), w});
    endtask

    task automatic drain(string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s: %0d words never seen, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic monitor();
        logic [DW+1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (n_rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_extra: got port %0d data %0h expected none",
                             out_port, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_port", 64'(out_port), 64'(e[DW+1:DW]));
                    check("sb_data", 64'(out_data), 64'(e[DW-1:0]));
                end
            end
            if (n_rst && fifo_rd_en != 4'b0000) begin
                check("rd_onehot", 64'($onehot(fifo_rd_en)), 64'd1);
                check("rd_nonempty", 64'(fifo_rd_en & fifo_empty), 64'd0);
            end
        end
    endtask

    initial begin
        int vcyc [$];
        n_rst      = 1'b0;
        out_ready  = 1'b0;
        fifo_empty <= 4'hF;
        fifo_rdata <= '0;
        fork
            monitor();
        join_none
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_port", 64'(out_port), 64'd0);
        n_rst = 1'b1;
        tick();

        // All four non-empty: 0,1,2,3,0 one word per 4 cycles
        push(0, 32'h0000_0A00);
        push(0, 32'h0000_0A01);
        push(1, 32'h0000_0B01);
        push(2, 32'h0000_0C02);
        push(3, 32'h0000_0D03);
        expect_word(0, 32'h0000_0A00);
        expect_word(1, 32'h0000_0B01);
        expect_word(2, 32'h0000_0C02);
        expect_word(3, 32'h0000_0D03);
        expect_word(0, 32'h0000_0A01);
        out_ready = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (out_valid) vcyc.push_back(c);
        end
        check("rr_count", 64'(vcyc.size()), 64'd5);
        check("rr_first", 64'(vcyc.size() > 0 ? vcyc[0] : 0), 64'd3);
        for (int i = 1; i < vcyc.size(); i++)
            check("rr_gap", 64'(vcyc[i] - vcyc[i-1]), 64'd4);
        drain("rr_drain");

        // Single source FIFO2, latency N+1 / N+3
        push(2, 32'hA5A5_0002);
        expect_word(2, 32'hA5A5_0002);
        tick();
        check("single_rd_n1", 64'(fifo_rd_en), 64'b0100);
        check("single_vld_n1", 64'(out_valid), 64'd0);
        tick();
        check("single_rd_n2", 64'(fifo_rd_en), 64'd0);
        check("single_vld_n2", 64'(out_valid), 64'd0);
        tick();
        check("single_vld_n3", 64'(out_valid), 64'd1);
        check("single_port_n3", 64'(out_port), 64'd2);
        tick();
        check("single_idle_vld", 64'(out_valid), 64'd0);
        check("single_idle_busy", 64'(busy), 64'd0);
        drain("single_drain");

        // Backpressure on FIFO1; FIFO3 written mid-SEND
        out_ready = 1'b0;
        push(1, 32'h1111_0001);
        expect_word(1, 32'h1111_0001);
        tick();
        tick();
        tick();
        push(3, 32'h3333_0003);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", 64'(out_data), 64'h1111_0001);
            check("bp_port", 64'(out_port), 64'd1);
            check("bp_rd_en", 64'(fifo_rd_en), 64'd0);
            tick();
        end
        check("bp_held6", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_after_vld", 64'(out_valid), 64'd0);
        check("bp_after_busy", 64'(busy), 64'd0);
        expect_word(3, 32'h3333_0003);
        drain("bp_drain");

        // Fairness between FIFO0 and FIFO3
        for (int i = 0; i < 3; i++) begin
            push(0, 32'h0000_F000 + DW'(i));
            push(3, 32'h0000_F300 + DW'(i));
            expect_word(0, 32'h0000_F000 + DW'(i));
            expect_word(3, 32'h0000_F300 + DW'(i));
        end
        drain("fair_drain");

        // Reset mid-SEND drops the word, then FIFO0 first
        out_ready = 1'b0;
        push(0, 32'hDEAD_0000);
        push(0, 32'h0000_1000);
        push(1, 32'h0000_1001);
        push(2, 32'h0000_1002);
        push(3, 32'h0000_1003);
        for (int t = 0; t < 10 && !out_valid; t++) tick();
        check("rst_reached_send", 64'(out_valid), 64'd1);
        n_rst = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        tick();
        n_rst = 1'b1;
        expect_word(0, 32'h0000_1000);
        expect_word(1, 32'h0000_1001);
        expect_word(2, 32'h0000_1002);
        expect_word(3, 32'h0000_1003);
        out_ready = 1'b1;
        drain("rst_drain");

`ifdef NOC_ARB_GRANT_CNT_EN
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("cnt_rst", 64'(grant_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            push(1, 32'h0000_C100 + DW'(i));
            expect_word(1, 32'h0000_C100 + DW'(i));
        end
        drain("cnt_drain3");
        check("cnt_three", 64'(grant_cnt), 64'b00_00_11_00);
        push(1, 32'h0000_C1FF);
        expect_word(1, 32'h0000_C1FF);
        drain("cnt_drain4");
        check("cnt_sat", 64'(grant_cnt), 64'b00_00_11_00);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
